// File: rtl/alu_input_sequencer.sv
// ---------------------------------------------------------------------------
// alu_input_sequencer
//
// Front-end controller for the registered ALU datapath. It synchronizes and
// debounces two push-buttons (enter, back) and walks the user through the
// fields A -> B -> OpCode -> result. Each accepted enter press in a load
// field registers the switch bank onto data_out together with a one-cycle
// load strobe. After the opcode load, updateRes pulses one cycle later so the
// consumer's opcode register has settled before the result is captured.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous reset, active low
//   switches    in   N  raw switch bank (quasi-static, not synchronized)
//   btn_enter   in   1  raw enter button, active high, asynchronous
//   btn_back    in   1  raw back button, active high, asynchronous
//   data_out    out  N  registered switch value loaded with each strobe
//   load_a      out  1  one-cycle strobe: load operand A
//   load_b      out  1  one-cycle strobe: load operand B
//   load_Op     out  1  one-cycle strobe: load opcode (data_out[1:0])
//   updateRes   out  1  one-cycle strobe: capture ALU result and flags
//   state_leds  out  4  one-hot field indicator {SHOW, OP, B, A}
//   dbg_state   out  3  raw FSM state for observation
//
// Strobe semantics: every strobe is a single-cycle, registered pulse with no
// ready/back-pressure; the consumer must accept it in the cycle it is high.
// data_out is valid in the strobe cycle and holds until the next load.
// ---------------------------------------------------------------------------
module alu_input_sequencer #(
  parameter int N               = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] switches,
  input  logic         btn_enter,
  input  logic         btn_back,
  output logic [N-1:0] data_out,
  output logic         load_a,
  output logic         load_b,
  output logic         load_Op,
  output logic         updateRes,
  output logic [3:0]   state_leds,
  output logic [2:0]   dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  // The increment that would reach DEBOUNCE_CYCLES is the one that accepts
  // the new level, so acceptance is decided when the counter holds CNT_LAST.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Button index 0 = enter, 1 = back.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_stable;
  logic [1:0]    r_stable_d;
  logic [CW-1:0] r_cnt [2];

  logic          w_enter_pulse;
  logic          w_back_pulse;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_data_out;
  logic          r_load_a;
  logic          r_load_b;
  logic          r_load_op;
  logic          r_update_res;
  logic [3:0]    r_leds;

  logic          w_capture;
  logic          w_load_a_next;
  logic          w_load_b_next;
  logic          w_load_op_next;
  logic          w_update_next;
  logic [3:0]    w_leds_next;

  assign w_raw = {btn_back, btn_enter};

  // Synchronizers, debounce counters and edge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          // Any return to the accepted level (bounce) restarts the count.
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // One pulse per press: rising edge of the debounced level only.
  assign w_enter_pulse = r_stable[0] & ~r_stable_d[0];
  assign w_back_pulse  = r_stable[1] & ~r_stable_d[1];

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_A;
      r_data_out   <= '0;
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_load_op    <= 1'b0;
      r_update_res <= 1'b0;
      r_leds       <= 4'b0001;
    end else begin
      r_state      <= w_state_next;
      r_load_a     <= w_load_a_next;
      r_load_b     <= w_load_b_next;
      r_load_op    <= w_load_op_next;
      r_update_res <= w_update_next;
      r_leds       <= w_leds_next;
      if (w_capture) begin
        r_data_out <= switches;
      end
    end
  end

  // Next-state and next-output logic. Enter is tested before back so a
  // simultaneous press resolves in favour of enter.
  always_comb begin
    w_state_next   = r_state;
    w_capture      = 1'b0;
    w_load_a_next  = 1'b0;
    w_load_b_next  = 1'b0;
    w_load_op_next = 1'b0;
    w_update_next  = 1'b0;
    w_leds_next    = 4'b0001;

    case (r_state)
      S_A: begin
        if (w_enter_pulse) begin
          w_capture     = 1'b1;
          w_load_a_next = 1'b1;
          w_state_next  = S_B;
        end
      end
      S_B: begin
        if (w_enter_pulse) begin
          w_capture     = 1'b1;
          w_load_b_next = 1'b1;
          w_state_next  = S_OP;
        end else if (w_back_pulse) begin
          w_state_next = S_A;
        end
      end
      S_OP: begin
        if (w_enter_pulse) begin
          w_capture      = 1'b1;
          w_load_op_next = 1'b1;
          w_state_next   = S_CALC;
        end else if (w_back_pulse) begin
          w_state_next = S_B;
        end
      end
      S_CALC: begin
        // Button pulses landing in this single cycle are intentionally lost.
        w_update_next = 1'b1;
        w_state_next  = S_SHOW;
      end
      S_SHOW: begin
        if (w_enter_pulse) begin
          w_state_next = S_A;
        end else if (w_back_pulse) begin
          w_state_next = S_OP;
        end
      end
      default: begin
        w_state_next = S_A;
      end
    endcase

    case (w_state_next)
      S_A:     w_leds_next = 4'b0001;
      S_B:     w_leds_next = 4'b0010;
      S_OP:    w_leds_next = 4'b0100;
      S_CALC:  w_leds_next = 4'b1000;
      S_SHOW:  w_leds_next = 4'b1000;
      default: w_leds_next = 4'b0001;
    endcase
  end

  assign data_out   = r_data_out;
  assign load_a     = r_load_a;
  assign load_b     = r_load_b;
  assign load_Op    = r_load_op;
  assign updateRes  = r_update_res;
  assign state_leds = r_leds;
  assign dbg_state  = r_state;

endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Front-end controller placed directly upstream of the registered ALU datapath: it takes the board switches and two push-buttons (enter, back), synchronizes and debounces the buttons, and steps a state machine that drives the ALU's `load_a`, `load_b`, `load_Op` and `updateRes` strobes with a registered copy of the switches on `data_out`. One enter press loads one operand or opcode, so the user enters A, B, OpCode in order and then sees the result. A back press re-enters the previous field.

## Interface
- `N`, 16: operand width; must match the ALU datapath width.
- `DEBOUNCE_CYCLES`, 1_000_000: number of consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).

- `clk`  in  1: single system clock; all logic rising-edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `switches`  in  N: raw switch bank, operand/opcode value; sampled without synchronizer (quasi-static).
- `btn_enter`  in  1: raw enter button, active-high, asynchronous.
- `btn_back`  in  1: raw back button, active-high, asynchronous.
- `data_out`  out  N: registered switch value presented with each load strobe.
- `load_a`  out  1: one-cycle strobe, load operand A.
- `load_b`  out  1: one-cycle strobe, load operand B.
- `load_Op`  out  1: one-cycle strobe, load opcode (consumer uses `data_out[1:0]`).
- `updateRes`  out  1: one-cycle strobe, capture ALU result and flags.
- `state_leds`  out  4: one-hot current field {SHOW, OP, B, A} (bit 0 = A).

## Operation
- Buttons: 2-FF synchronizer each, reset to 0.
- Debounce per button: `stable` level and counter (width clog2(DEBOUNCE_CYCLES)+1). Counter clears whenever the synchronized level equals `stable`. It increments while they differ; on reaching DEBOUNCE_CYCLES, `stable` takes the new level and the counter clears.
- Press pulse = `stable` rising edge (registered previous `stable`). Exactly one pulse per press regardless of hold time; release generates nothing.
- FSM states: S_A, S_B, S_OP, S_CALC, S_SHOW. Reset state S_A.
  - S_A: enter → register `data_out <= switches`, `load_a` = 1 next cycle; go S_B.
  - S_B: enter → `data_out <= switches`, `load_b` pulse; go S_OP. back → S_A.
  - S_OP: enter → `data_out <= switches`, `load_Op` pulse; go S_CALC. back → S_B.
  - S_CALC: unconditional; `updateRes` pulse registered here (high the cycle after `load_Op`); go S_SHOW. Button pulses in this cycle are dropped.
  - S_SHOW: enter → S_A (no strobe). back → S_OP, which allows reloading only the opcode and recomputing.
  - back in S_A: no effect.
- Enter and back pulses in the same cycle: enter wins, back ignored.
- `data_out` holds its last loaded value between strobes and changes only on an accepted enter in S_A/S_B/S_OP.
- `state_leds`: S_A = 0001, S_B = 0010, S_OP = 0100, S_CALC and S_SHOW = 1000.

## Timing
- Reset (asynchronous, `reset` = 0): state S_A; `data_out` = 0; all strobes = 0; `state_leds` = 0001; synchronizers, stable levels, edge registers and counters = 0.
- A button held through reset release is seen as a press after the normal debounce time.
- Latency: let edge 0 be the first clk edge sampling the raw button high (held continuously). `stable` rises after edge DEBOUNCE_CYCLES+1. The strobe and the new `data_out` become valid after edge DEBOUNCE_CYCLES+2 and last exactly one cycle.
- `updateRes` is high exactly one cycle, in the cycle after `load_Op`. This gives the consumer's opcode register one edge to update before the result is captured.
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no pulse. Bounce resets the counter.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, DEBOUNCE_CYCLES = 4, N = 16: hold `reset` = 0 → all strobes 0, `data_out` = 0x0000, `state_leds` = 0001. Release and hold enter high from edge 0 with `switches` = 0x1234 → `load_a` high only after edge 6, `data_out` = 0x1234, `state_leds` = 0010.
- Full sequence with presses and `switches` = 0x1234 / 0x0011 / 0x0002 → one pulse each of `load_a`, `load_b`, `load_Op` with matching `data_out`. `updateRes` follows `load_Op` by exactly 1 cycle, then `state_leds` = 1000.
- Bounce: enter toggled 1,1,1,0,1,1,1,0 cycles → no strobe, state unchanged. Enter then held 5 cycles → exactly one strobe.
- Back path: in S_SHOW, press back → `state_leds` = 0100. Enter with `switches` = 0x0003 → `load_Op`, `data_out` = 0x0003, then `updateRes`. In S_A, back → stays 0001.
- Simultaneous press: enter and back rising together in S_B → `load_b` pulse, state S_OP.
- Reset mid-operation: assert `reset` low in S_OP while enter is debouncing → immediate S_A, all strobes 0, and no strobe after release until a new full press.
